bus_arbiter8: RTL and testbench

Round-robin arbiter that shares one 16-bit output channel among 8 requesters, granting one requester at a time for a burst of up to BURST_MAX words. The data path uses the existing Mux8Way16 and DMux8Way primitives; this block adds the sequencing: the grant FSM, rotating priority, burst counting and the valid/ready handshake. It sits between multiple word producers (e.g. DMA or I/O sources) and a single consumer port.

---
 rtl/bus_arbiter8_pkg.sv | 11 +
 rtl/bus_arbiter8_prims.sv | 27 ++
 rtl/bus_arbiter8_rr_pick8.sv | 25 ++
 rtl/bus_arbiter8.sv | 83 ++++++++
 tb/tb_bus_arbiter8.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter8_pkg.sv
// rtl/bus_arbiter8_pkg.sv - shared constants and helpers for the 8-way bus arbiter
package bus_arbiter8_pkg;
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_XFER = 1'b1;
    localparam int         WORD_W   = 16;
    localparam int         N_REQ    = 8;

    function automatic logic [N_REQ-1:0] onehot8(input logic [2:0] s);
        return 8'b0000_0001 << s;
    endfunction
endpackage

// File: rtl/bus_arbiter8_prims.sv
// rtl/bus_arbiter8_prims.sv - Or8Way, Mux8Way16 and DMux8Way data-path primitives
module Or8Way (
    input  logic [7:0] i_in,
    output logic       o_out
);
    assign o_out = |i_in;
endmodule

module Mux8Way16
    import bus_arbiter8_pkg::*;
(
    input  logic [8*WORD_W-1:0] i_words,
    input  logic [2:0]          i_sel,
    output logic [WORD_W-1:0]   o_out
);
    assign o_out = i_words[i_sel*WORD_W +: WORD_W];
endmodule

module DMux8Way
    import bus_arbiter8_pkg::*;
(
    input  logic       i_in,
    input  logic [2:0] i_sel,
    output logic [7:0] o_out
);
    assign o_out = i_in ? onehot8(i_sel) : 8'h00;
endmodule

// File: rtl/bus_arbiter8_rr_pick8.sv
// rtl/bus_arbiter8_rr_pick8.sv - combinational round-robin pick starting at ptr
module rr_pick8 (
    input  logic [7:0] i_req,
    input  logic [2:0] i_ptr,
    output logic [2:0] o_idx,
    output logic       o_any
);
    logic [2:0] w_cand;
    logic       w_found;

    Or8Way u_or (.i_in(i_req), .o_out(o_any));

    always_comb begin
        o_idx   = 3'd0;
        w_found = 1'b0;
        w_cand  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_cand = i_ptr + k[2:0];
            if (!w_found && i_req[w_cand]) begin
                o_idx   = w_cand;
                w_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter8.sv
// rtl/bus_arbiter8.sv - round-robin burst arbiter sharing one word channel among 8 requesters
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BURST_MAX = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         grant,
    output logic [2:0]         sel,
    output logic [7:0]         ack,
    output logic               busy
);
    logic [0:0] r_state;
    logic [2:0] r_sel;
    logic [2:0] r_ptr;
    logic [7:0] r_grant;
    logic [3:0] r_count;

    logic [2:0]        w_next_ptr;
    logic [2:0]        w_pick_ptr;
    logic [2:0]        w_idx;
    logic              w_any;
    logic              w_hs;
    logic              w_last;
    logic              w_release;
    logic [WORD_W-1:0] w_mux;

    assign w_next_ptr = r_sel + 3'd1;
    // On release the next owner is chosen in the same edge, so scan from sel+1 rather than r_ptr.
    assign w_pick_ptr = (r_state == ARB_XFER) ? w_next_ptr : r_ptr;

    rr_pick8 u_pick (.i_req(req), .i_ptr(w_pick_ptr), .o_idx(w_idx), .o_any(w_any));

    Mux8Way16 u_mux (.i_words(in_data), .i_sel(r_sel), .o_out(w_mux));

    DMux8Way u_ack (.i_in(w_hs), .i_sel(r_sel), .o_out(ack));

    assign out_valid = (r_state == ARB_XFER) && req[r_sel];
    assign out_data  = w_mux & {WORD_W{out_valid}};
    assign w_hs      = out_valid && out_ready;
    assign w_last    = (r_count == 4'(BURST_MAX - 1));
    assign w_release = (r_state == ARB_XFER) && ((w_hs && w_last) || !req[r_sel]);

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = (r_state == ARB_XFER);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_grant <= 8'h00;
            r_count <= 4'd0;
        end else if (r_state == ARB_IDLE) begin
            if (w_any) begin
                r_sel   <= w_idx;
                r_grant <= onehot8(w_idx);
                r_count <= 4'd0;
                r_state <= ARB_XFER;
            end
        end else if (w_release) begin
            r_ptr <= w_next_ptr;
            if (w_any) begin
                r_sel   <= w_idx;
                r_grant <= onehot8(w_idx);
                r_count <= 4'd0;
            end else begin
                r_grant <= 8'h00;
                r_state <= ARB_IDLE;
            end
        end else if (w_hs) begin
            r_count <= r_count + 4'd1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter8.sv
// tb/tb_bus_arbiter8.sv - scoreboard bench for bus_arbiter8
module tb_bus_arbiter8;
    typedef struct packed {
        logic [7:0]  grant;
        logic [15:0] data;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [7:0]   req;
    logic [127:0] in_data;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   grant;
    logic [2:0]   sel;
    logic [7:0]   ack;
    logic         busy;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    bus_arbiter8 #(.WIDTH(16), .BURST_MAX(4)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .sel(sel), .ack(ack), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_total++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
    endtask

    function automatic logic [15:0] word(input int i);
        return {4'(i + 1), 4'hC, 4'(i), 4'h3};
    endfunction

    task automatic push(input logic [7:0] g, input logic [15:0] d);
        exp_t e;
        e.grant = g;
        e.data  = d;
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted word must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_hs", {24'h0, ack}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("hs_grant", {24'h0, grant}, {24'h0, e.grant});
                    check("hs_data", {16'h0, out_data}, {16'h0, e.data});
                    check("hs_ack", {24'h0, ack}, {24'h0, e.grant});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[16*i +: 16] = word(i);

        // Reset with all requesting, then a full rotation plus one more burst for requester 0.
        repeat (2) @(posedge clock);
        #2;
        check("rst_grant", {24'h0, grant}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", {16'h0, out_data}, 32'h0);
        check("rst_ack", {24'h0, ack}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int g = 0; g < 9; g++)
            for (int w = 0; w < 4; w++) push(8'h01 << (g % 8), word(g % 8));
        @(posedge clock); #2;
        check("first_grant", {24'h0, grant}, 32'h01);
        repeat (35) @(posedge clock);
        @(posedge clock); #1;
        check("rotation_no_gap", sb_q.size(), 32'd0);
        req = 8'h00;

        // Single requester 3 with a specific word.
        @(posedge clock); #1;
        in_data[63:48] = 16'h1234;
        req = 8'h08;
        push(8'h08, 16'h1234);
        @(posedge clock); #2;
        check("t2_sel", {29'h0, sel}, 32'd3);
        check("t2_grant", {24'h0, grant}, 32'h08);
        check("t2_valid", {31'h0, out_valid}, 32'h1);
        check("t2_data", {16'h0, out_data}, 32'h1234);
        check("t2_ack", {24'h0, ack}, 32'h08);
        @(posedge clock); #1;
        req = 8'h00;

        // Backpressure on requester 5 for five cycles, then exactly one word.
        @(posedge clock); #1;
        req = 8'h20;
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clock); #2;
            check("bp_grant", {24'h0, grant}, 32'h20);
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_data", {16'h0, out_data}, {16'h0, word(5)});
            check("bp_ack", {24'h0, ack}, 32'h0);
        end
        out_ready = 1'b1;
        push(8'h20, word(5));
        @(posedge clock); #1;
        req = 8'h00;

        // Requester 2 withdraws before any handshake; scan resumes at 3 so 6 beats 0.
        @(posedge clock); #1;
        req = 8'h04;
        out_ready = 1'b0;
        @(posedge clock); #2;
        check("w_grant2", {24'h0, grant}, 32'h04);
        req = 8'h41;
        @(posedge clock); #2;
        check("w_grant6", {24'h0, grant}, 32'h40);
        check("w_sel6", {29'h0, sel}, 32'd6);
        check("w_ack", {24'h0, ack}, 32'h0);
        check("w_busy", {31'h0, busy}, 32'h1);
        @(posedge clock); #1;
        req = 8'h00;

        // Two words from requester 4, then asynchronous reset mid-burst.
        @(posedge clock); #1;
        req = 8'h10;
        out_ready = 1'b1;
        push(8'h10, word(4));
        push(8'h10, word(4));
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        req = 8'h11;
        #1;
        check("mid_rst_grant", {24'h0, grant}, 32'h0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_data", {16'h0, out_data}, 32'h0);
        check("mid_rst_ack", {24'h0, ack}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_words", sb_q.size(), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        push(8'h01, word(0));
        @(posedge clock); #2;
        check("post_rst_grant", {24'h0, grant}, 32'h01);
        check("post_rst_sel", {29'h0, sel}, 32'd0);
        @(posedge clock); #1;
        req = 8'h00;
        repeat (3) @(posedge clock);
        #2;
        check("sb_drained", sb_q.size(), 32'd0);
        check("end_idle", {24'h0, grant}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
